// File: rtl/pipe_ctrl_pkg.sv
// Shared types and elaboration helpers for the pipeline register chain.
//   pipe_state_e       : halt/drain state machine encoding
//   chain_params_legal : parameter legality check used at elaboration
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PS_RUN    = 2'd0,
    PS_DRAIN  = 2'd1,
    PS_HALTED = 2'd2
  } pipe_state_e;

  // NSTAGES>=2, the bubble stage must exist, and the flush zone must
  // cover every stall-frozen stage without running past the chain.
  function automatic bit chain_params_legal(input int unsigned nstages,
                                            input int unsigned stall_idx,
                                            input int unsigned flush_depth);
    return (nstages >= 2) &&
           (stall_idx + 1 < nstages) &&
           (stall_idx < flush_depth) &&
           (flush_depth <= nstages);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid bit plus opaque payload.
//   clk, reset  : clock, synchronous active-high reset
//   hold        : keep current contents
//   clear       : load a bubble (valid=0, data=0); wins over hold
//   load_valid  : valid offered by the upstream stage
//   load_data   : payload offered by the upstream stage
//   valid, data : registered stage contents (data is 0 whenever !valid)
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (!hold) begin
      valid <= load_valid;
      data  <= load_valid ? load_data : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain with stall, flush, bubble injection and
// a halt/drain state machine.
//   clk, reset   : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : stage-0 issue handshake
//   stall        : freeze stages 0..STALL_IDX, bubble into STALL_IDX+1
//   flush        : clear stages 0..FLUSH_DEPTH-1
//   halt_req     : stop issue and drain; resume leaves HALTED
//   stage_valid/stage_data : per-stage contents, stage k at [k*DATA_W +: DATA_W]
//   out_valid/out_data     : last stage
//   occupancy    : number of valid stages
//   halted       : chain is drained and issue is stopped
module pipe_stage_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NSTAGES     = 4,
  parameter int unsigned STALL_IDX   = 0,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_ready,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           halt_req,
  input  logic                           resume,
  output logic [NSTAGES-1:0]             stage_valid,
  output logic [NSTAGES*DATA_W-1:0]      stage_data,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(NSTAGES+1)-1:0]   occupancy,
  output logic                           halted
);

  localparam int unsigned OCC_W = $clog2(NSTAGES + 1);

  if (!chain_params_legal(NSTAGES, STALL_IDX, FLUSH_DEPTH)) begin : g_bad_params
    $fatal(1, "pipe_stage_chain: illegal NSTAGES/STALL_IDX/FLUSH_DEPTH combination");
  end

  pipe_state_e       state;
  logic [NSTAGES-1:0] stage_hold;
  logic [NSTAGES-1:0] stage_clear;
  logic              valid_q [NSTAGES];
  logic [DATA_W-1:0] data_q  [NSTAGES];

  assign in_ready = (state == PS_RUN) && !stall;
  assign halted   = (state == PS_HALTED);

  // Flush and the stall bubble both become a clear; clear outranks hold
  // inside the stage register, which gives flush priority over stall.
  always_comb begin
    stage_hold  = '0;
    stage_clear = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      stage_hold[k]  = stall && (k <= STALL_IDX);
      stage_clear[k] = (flush && (k < FLUSH_DEPTH)) || (stall && (k == STALL_IDX + 1));
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;

    if (k == 0) begin : g_head
      assign ld_valid = in_valid && in_ready;
      assign ld_data  = in_data;
    end else begin : g_body
      assign ld_valid = valid_q[k-1];
      assign ld_data  = data_q[k-1];
    end

    pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
      .clk        (clk),
      .reset      (reset),
      .hold       (stage_hold[k]),
      .clear      (stage_clear[k]),
      .load_valid (ld_valid),
      .load_data  (ld_data),
      .valid      (valid_q[k]),
      .data       (data_q[k])
    );
  end

  always_comb begin
    stage_valid = '0;
    stage_data  = '0;
    occupancy   = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      stage_valid[k]                 = valid_q[k];
      stage_data[k*DATA_W +: DATA_W] = data_q[k];
      occupancy                      = occupancy + OCC_W'(valid_q[k]);
    end
  end

  assign out_valid = valid_q[NSTAGES-1];
  assign out_data  = data_q[NSTAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PS_RUN;
    end else begin
      case (state)
        PS_RUN:    if (halt_req)          state <= PS_DRAIN;
        PS_DRAIN:  if (occupancy == '0)   state <= PS_HALTED;
        PS_HALTED: if (resume)            state <= PS_RUN;
        default:                          state <= PS_RUN;
      endcase
    end
  end

endmodule
